// File: rtl/pwm_analyzer_mc_pkg.sv
// Shared encodings for the multi-channel PWM analyzer: class codes, channel
// FSM states and seven-segment glyphs.
package pwm_analyzer_pkg;

  typedef enum logic [1:0] {
    CLS_LOST = 2'd0,
    CLS_LOW  = 2'd1,
    CLS_MID  = 2'd2,
    CLS_HIGH = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } ch_state_e;

  localparam logic [6:0] SEG_LOST = 7'b0000000;
  localparam logic [6:0] SEG_LOW  = 7'b0111000;
  localparam logic [6:0] SEG_MID  = 7'b1000000;
  localparam logic [6:0] SEG_HIGH = 7'b1110110;
  localparam logic [6:0] SEG_ERR  = 7'b1111001;

  function automatic logic [6:0] seg_of(input logic [1:0] c);
    case (cls_e'(c))
      CLS_LOW:  return SEG_LOW;
      CLS_MID:  return SEG_MID;
      CLS_HIGH: return SEG_HIGH;
      default:  return SEG_LOST;
    endcase
  endfunction

endpackage

// File: rtl/pwm_analyzer_mc_channel.sv
// One PWM channel: input synchronizer, pulse-width FSM, timeout watchdog and
// hysteretic classifier.
module pwm_channel
  import pwm_analyzer_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int MAX_COUNT   = 2000,
  parameter int HIGH_THR    = 1900,
  parameter int LOW_THR     = 1100,
  parameter int HYST        = 20,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm,
  output logic             valid,
  output logic             err,
  output logic [1:0]       cls,
  output logic [CNT_W-1:0] width
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] HI_ENTER = CNT_W'(HIGH_THR);
  localparam logic [CNT_W-1:0] LO_ENTER = CNT_W'(LOW_THR);
  localparam logic [CNT_W-1:0] HI_EXIT  = CNT_W'(HIGH_THR - HYST);
  localparam logic [CNT_W-1:0] LO_EXIT  = CNT_W'(LOW_THR + HYST);

  if (MAX_COUNT + 1 >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for MAX_COUNT");
  end

  logic             s_meta, s_sync, s_dly;
  logic             rise, fall;
  ch_state_e        state, state_n;
  logic             cap, ovf;
  logic [CNT_W-1:0] cnt, cap_w;
  logic [TMO_W-1:0] tmo;
  logic [1:0]       vld_pipe;
  cls_e             cls_q, cls_n;

  // Preset high so a pulse already in progress at reset never looks like a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) {s_meta, s_sync, s_dly} <= 3'b111;
    else begin
      s_meta <= pwm;
      s_sync <= s_meta;
      s_dly  <= s_sync;
    end
  end

  assign rise = s_sync & ~s_dly;
  assign fall = ~s_sync & s_dly;

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    ovf     = 1'b0;
    case (state)
      WAIT_LOW:  if (!s_sync) state_n = WAIT_RISE;
      WAIT_RISE: if (rise) state_n = MEASURE;
      MEASURE: begin
        if (fall) begin
          cap     = 1'b1;
          state_n = WAIT_RISE;
        end else if (cnt == CNT_MAX) begin
          ovf     = 1'b1;
          state_n = WAIT_LOW;
        end
      end
      default: state_n = WAIT_LOW;
    endcase
  end

  always_comb begin
    if (cap_w > HI_ENTER)      cls_n = CLS_HIGH;
    else if (cap_w < LO_ENTER) cls_n = CLS_LOW;
    else                       cls_n = CLS_MID;
    if (cls_q == CLS_HIGH && cap_w >= HI_EXIT) cls_n = CLS_HIGH;
    if (cls_q == CLS_LOW && cap_w <= LO_EXIT)  cls_n = CLS_LOW;
  end

  // Capture is staged once so the result lands three cycles after the low sample.
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      state    <= WAIT_LOW;
      cnt      <= '0;
      cap_w    <= '0;
      tmo      <= '0;
      vld_pipe <= '0;
      width    <= '0;
      cls_q    <= CLS_LOST;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      vld_pipe <= {vld_pipe[0], cap};
      if (state == WAIT_RISE && rise)             cnt <= CNT_W'(1);
      else if (state == MEASURE && s_sync && !ovf) cnt <= cnt + 1'b1;
      if (cap) cap_w <= cnt;
      if (ovf) err <= 1'b1;
      if (rise)                tmo <= '0;
      else if (tmo != TMO_END) tmo <= tmo + 1'b1;
      if (vld_pipe[0]) begin
        width <= cap_w;
        cls_q <= cls_n;
      end else if (!rise && tmo == TMO_LAST) begin
        cls_q <= CLS_LOST;
      end
    end
  end

  assign valid = vld_pipe[1];
  assign cls   = cls_q;

endmodule

// File: rtl/pwm_analyzer_mc.sv
// Multi-channel PWM analyzer: per-channel measurement plus a registered
// seven-segment / width readout of the selected channel.
module pwm_analyzer_mc
  import pwm_analyzer_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 12,
  parameter int MAX_COUNT   = 2000,
  parameter int HIGH_THR    = 1900,
  parameter int LOW_THR     = 1100,
  parameter int HYST        = 20,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        ena,
  input  logic [NUM_CH-1:0]                           pwm_in,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] sel,
  output logic [6:0]                                  seg,
  output logic [2*NUM_CH-1:0]                         class_o,
  output logic [CNT_W-1:0]                            width_o,
  output logic [NUM_CH-1:0]                           valid_o,
  output logic [NUM_CH-1:0]                           err_o
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_check
    $error("NUM_CH must be 1..8");
  end

  logic [NUM_CH-1:0][CNT_W-1:0] ch_width;
  logic                         sel_hit;
  logic [1:0]                   sel_cls;
  logic [CNT_W-1:0]             sel_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W      (CNT_W),
      .MAX_COUNT  (MAX_COUNT),
      .HIGH_THR   (HIGH_THR),
      .LOW_THR    (LOW_THR),
      .HYST       (HYST),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .pwm  (pwm_in[i]),
      .valid(valid_o[i]),
      .err  (err_o[i]),
      .cls  (class_o[2*i +: 2]),
      .width(ch_width[i])
    );
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_cls = '0;
    sel_w   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit = 1'b1;
        sel_cls = class_o[2*i +: 2];
        sel_w   = ch_width[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      seg     <= '0;
      width_o <= '0;
    end else if (!sel_hit) begin
      seg     <= SEG_ERR;
      width_o <= '0;
    end else begin
      seg     <= seg_of(sel_cls);
      width_o <= sel_w;
    end
  end

endmodule

// File: tb/tb_pwm_analyzer_mc.sv
// Scoreboard bench for pwm_analyzer_mc: pulse drivers push expected results,
// a negedge monitor pops and compares on every valid_o strobe.
module tb_pwm_analyzer_mc;

  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 12;
  localparam int MAX_COUNT = 2000;
  localparam int HIGH_THR  = 1900;
  localparam int LOW_THR   = 1100;
  localparam int HYST      = 20;
  localparam int T         = 5000; // shortened timeout keeps the run short

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ena = 1'b0;
  logic [NUM_CH-1:0]   pwm_in = '0;
  logic [1:0]          sel = '0;
  logic [6:0]          seg;
  logic [2*NUM_CH-1:0] class_o;
  logic [CNT_W-1:0]    width_o;
  logic [NUM_CH-1:0]   valid_o;
  logic [NUM_CH-1:0]   err_o;

  pwm_analyzer_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT), .HIGH_THR(HIGH_THR),
    .LOW_THR(LOW_THR), .HYST(HYST), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in), .sel(sel), .seg(seg),
    .class_o(class_o), .width_o(width_o), .valid_o(valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int w; int cls; int due; } exp_t;
  exp_t exp_q[NUM_CH][$];
  int   cls_m[NUM_CH];
  int   err_m[NUM_CH];
  int   last_rise[NUM_CH];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int next_class(input int prev, input int w);
    int base = (w > HIGH_THR) ? 3 : (w < LOW_THR) ? 1 : 2;
    if (prev == 3 && w >= HIGH_THR - HYST) return 3;
    if (prev == 1 && w <= LOW_THR + HYST) return 1;
    return base;
  endfunction

  function automatic int seg_m(input int c);
    case (c)
      1: return 7'b0111000;
      2: return 7'b1000000;
      3: return 7'b1110110;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NUM_CH; i++) begin
      cls_m[i] = 0;
      err_m[i] = 0;
    end
  endtask

  // High for w sampling edges; the low is first sampled on the next edge.
  task automatic pulse(input int ch, input int w, input int gap);
    @(negedge clk);
    pwm_in[ch] = 1'b1;
    last_rise[ch] = cyc + 1;
    repeat (w) @(negedge clk);
    pwm_in[ch] = 1'b0;
    if (w <= MAX_COUNT) begin
      cls_m[ch] = next_class(cls_m[ch], w);
      exp_q[ch].push_back('{w: w, cls: cls_m[ch], due: cyc + 4});
    end else begin
      err_m[ch] = 1;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  exp_t mon_e;
  logic pend = 1'b0;
  int   pend_w, pend_seg;

  always @(negedge clk) begin
    if (pend) begin
      chk("width_o", int'(width_o), pend_w);
      chk("seg", int'(seg), pend_seg);
      pend = 1'b0;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (valid_o[ch]) begin
        if (exp_q[ch].size() == 0) chk("spurious_valid", int'(valid_o[ch]), 0);
        else begin
          mon_e = exp_q[ch].pop_front();
          chk("valid_cycle", cyc, mon_e.due);
          chk("class", int'(class_o[2*ch +: 2]), mon_e.cls);
          if (ch == int'(sel)) begin
            pend     = 1'b1;
            pend_w   = mon_e.w;
            pend_seg = seg_m(mon_e.cls);
          end
        end
      end else if (exp_q[ch].size() > 0 && exp_q[ch][0].due < cyc) begin
        mon_e = exp_q[ch].pop_front();
        chk("valid_missing", cyc, mon_e.due);
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: cycle budget exhausted");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  int p1;

  initial begin
    reset_model();
    ena = 1'b1;
    pwm_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_class", int'(class_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_seg", int'(seg), 0);
    chk("rst_width", int'(width_o), 0);
    rst_n = 1'b1;
    // pulse already high at reset release must be discarded
    repeat (300) @(negedge clk);
    pwm_in[0] = 1'b0;
    repeat (200) @(negedge clk);
    pulse(0, 1200, 600);
    chk("cls_after_1200", int'(class_o[1:0]), 2);

    pulse(0, 1500, 1000);
    pulse(0, 1500, 1000);
    pulse(0, 1950, 600);
    pulse(0, 1890, 600);
    pulse(0, 1870, 600);
    pulse(0, 1000, 600);
    chk("seg_low", int'(seg), 7'b0111000);

    pulse(0, 2500, 600);
    chk("err_overlong", int'(err_o[0]), 1);
    chk("cls_kept", int'(class_o[1:0]), cls_m[0]);
    pulse(0, 1500, 600);
    chk("err_sticky", int'(err_o[0]), 1);
    chk("width_after_err", int'(width_o), 1500);

    for (int k = 0; k < 6; k++) begin
      pulse(0, int'($urandom_range(900, 2100)), int'($urandom_range(300, 1500)));
      chk("err_rand", int'(err_o[0]), err_m[0]);
    end

    // reset in mid-pulse
    @(negedge clk);
    pwm_in[0] = 1'b1;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    repeat (400) @(negedge clk);
    pwm_in[0] = 1'b0;
    repeat (50) @(negedge clk);
    chk("midrst_class", int'(class_o), 0);
    chk("midrst_err", int'(err_o), 0);
    pulse(0, 1200, 600);
    pulse(0, 2000, 600);
    chk("err_at_max", int'(err_o[0]), 0);
    pulse(0, 2001, 600);
    chk("err_max_plus1", int'(err_o[0]), 1);

    // ena dropped in mid-pulse
    @(negedge clk);
    pwm_in[0] = 1'b1;
    repeat (400) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_class", int'(class_o), 0);
    chk("ena_seg", int'(seg), 0);
    chk("ena_err", int'(err_o), 0);
    ena = 1'b1;
    reset_model();
    repeat (400) @(negedge clk);
    pwm_in[0] = 1'b0;
    repeat (50) @(negedge clk);
    pulse(0, 1200, 600);

    // timeout to LOST
    p1 = last_rise[0];
    wait_cyc(p1 + 2 + T - 1);
    chk("pre_timeout", int'(class_o[1:0]), cls_m[0]);
    @(negedge clk);
    chk("timeout_lost", int'(class_o[1:0]), 0);
    cls_m[0] = 0;
    @(negedge clk);
    chk("timeout_seg", int'(seg), 0);

    // rising edge coincident with expiry
    pulse(0, 1500, 600);
    p1 = last_rise[0];
    wait_cyc(p1 + T - 2);
    fork
      pulse(0, 1600, 600);
      begin
        wait_cyc(p1 + T + 2);
        chk("edge_on_expiry", int'(class_o[1:0]), 2);
      end
    join

    @(negedge clk);
    sel = 2'd3;
    @(negedge clk);
    chk("sel_oob_seg", int'(seg), 7'b1111001);
    chk("sel_oob_width", int'(width_o), 0);
    sel = 2'd0;

    fork
      pulse(0, 1000, 600);
      pulse(1, 1500, 600);
      pulse(2, 1950, 600);
    join
    chk("concurrent_class", int'(class_o), 6'b111001);
    @(negedge clk);
    sel = 2'd1;
    @(negedge clk);
    chk("sel1_width", int'(width_o), 1500);
    chk("sel1_seg", int'(seg), 7'b1000000);
    sel = 2'd2;
    @(negedge clk);
    chk("sel2_width", int'(width_o), 1950);
    chk("sel2_seg", int'(seg), 7'b1110110);

    repeat (10) @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) chk("queue_drained", exp_q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
